part_profile_capture: RTL and testbench
=======================================

PART_PROFILE_CAPTURE -- requirements
Module: part_profile_capture

Interface
REQ-001 Parameter DATA_W, default 12, width of CCD sample words.
REQ-002 Parameter ADDR_W, default 10, profile memory address width; depth = 2**ADDR_W.
REQ-003 Parameter END_MARK, default 882, sample value delimiting a scan line (no part present).
REQ-004 Parameter TOL, default 4, maximum absolute sample difference accepted in inspect mode.
REQ-005 clk  in  1  system clock (50 MHz); one clock only.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  single-cycle request to begin an operation.
REQ-008 mode  in  1  0 = learn (store reference profile), 1 = inspect (compare against stored profile); sampled with start.
REQ-009 in_valid  in  1  one-cycle strobe, sample on in_data is valid (from ccd_reader).
REQ-010 in_data  in  DATA_W  CCD sample.
REQ-011 ccd_en  out  1  enable to ccd_reader.
REQ-012 mem_addr  out  ADDR_W  profile memory address.
REQ-013 mem_wdata  out  DATA_W  profile memory write data.
REQ-014 mem_wren  out  1  profile memory write enable.
REQ-015 mem_rdata  in  DATA_W  profile memory read data, valid one clk after mem_addr.
REQ-016 busy  out  1  operation in progress.
REQ-017 done  out  1  one-cycle pulse at end of operation.
REQ-018 pass  out  1  inspect verdict, valid from done until next start.
REQ-019 overflow  out  1  profile exceeded memory depth, valid from done.
REQ-020 ref_len  out  ADDR_W  number of samples stored by last completed learn.
REQ-021 err_cnt  out  ADDR_W  out-of-tolerance samples in last inspect, saturating.
REQ-022 state_o  out  2  current state, for 7-segment display.

Function
REQ-023 States: IDLE(0), SYNC(1), ACQ(2), FINISH(3); state_o equals state code.
REQ-024 IDLE: start=1 latches mode, clears err_cnt/pass/overflow, address counter := 0, -> SYNC next cycle; start ignored in any other state.
REQ-025 SYNC: ccd_en=1; in_valid with in_data==END_MARK stays; in_valid with in_data!=END_MARK -> ACQ and that sample is processed as the first profile sample.
REQ-026 ACQ: ccd_en=1; in_valid with in_data==END_MARK -> FINISH; in_valid with in_data==0 is skipped (no write, no compare, no address advance).
REQ-027 Learn, nonzero sample: mem_wdata:=in_data, mem_wren=1 for exactly one cycle at current address, address +1 after.
REQ-028 Inspect, nonzero sample: mem_addr = current address, compare |in_data - mem_rdata| one cycle later using registered in_data; difference > TOL increments err_cnt (saturates at all-ones).
REQ-029 Difference computed at DATA_W+1 bits unsigned-safe; no wrap.
REQ-030 Address == 2**ADDR_W-1 after a stored/compared sample -> overflow:=1, -> FINISH; further samples discarded.
REQ-031 FINISH (one cycle): ccd_en=0, done=1, -> IDLE; learn without overflow sets ref_len := address count; learn with overflow leaves ref_len unchanged.
REQ-032 Inspect pass = (err_cnt==0) and (address count == ref_len) and not overflow.
REQ-033 in_valid in IDLE or FINISH is ignored; mem_wren never asserted in inspect mode.
REQ-034 busy = 1 in SYNC, ACQ, FINISH.

Reset
REQ-035 rst_n=0 at any clk edge, including mid-operation: state IDLE, ccd_en/mem_wren/busy/done/pass/overflow=0, mem_addr/mem_wdata/err_cnt/ref_len=0; memory contents untouched.

Configuration
REQ-036 Macro PART_PROFILE_TIMEOUT_EN: when defined, parameter TIMEOUT_CYC (default 2**20) counts clk cycles without in_valid in SYNC/ACQ; reaching it -> FINISH with overflow=1, pass=0, timeout counter reset on every in_valid; when undefined no counter exists and SYNC/ACQ wait indefinitely.

Structure
REQ-037 Shared package part_pkg holds the state encoding and default DATA_W, ADDR_W, END_MARK, TOL constants.
REQ-038 One sub-module, profile_cmp, computes tolerance comparison (registered in_data vs mem_rdata -> mismatch bit).

Verification
REQ-039 Learn: start, mode=0, samples 882,882,100,0,120,130,882 -> writes 100@0,120@1,130@2, ref_len=3, done one cycle.
REQ-040 Inspect match: after REQ-039, mode=1, samples 882,102,0,118,133,882 -> err_cnt=0, pass=1.
REQ-041 Inspect mismatch: samples 882,100,140,130,882 -> err_cnt=1, pass=0; length 2 vs 3 case samples 882,100,120,882 -> pass=0.
REQ-042 Overflow: ADDR_W=3, learn 8 nonzero non-END samples -> overflow=1 after the 7th, ref_len unchanged, done pulse.
REQ-043 Reset mid-ACQ: rst_n=0 one cycle during ACQ -> state_o=0, ccd_en=0, mem_wren=0 next cycle; start ignored while busy.
REQ-044 With PART_PROFILE_TIMEOUT_EN, TIMEOUT_CYC=16: start, no in_valid -> FINISH after 16 cycles, overflow=1, pass=0.

Source files
------------

// File: rtl/part_pkg.sv
// Shared state encoding and default geometry for the part profile capture block.
package part_pkg;

    localparam int DEF_DATA_W   = 12;
    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_END_MARK = 882;
    localparam int DEF_TOL      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACQ    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/profile_cmp.sv
// Tolerance check of one captured sample against the stored reference word.
module profile_cmp
    import part_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TOL    = DEF_TOL
) (
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] ref_word,
    output logic              mismatch
);

    logic [DATA_W:0] a;
    logic [DATA_W:0] b;
    logic [DATA_W:0] diff;

    // One extra bit so the subtraction can never wrap.
    always_comb begin
        a        = {1'b0, sample};
        b        = {1'b0, ref_word};
        diff     = (a >= b) ? (a - b) : (b - a);
        mismatch = diff > (DATA_W + 1)'(TOL);
    end

endmodule

// File: rtl/part_profile_capture.sv
// Learns a reference part profile from CCD scan lines and inspects later parts against it.
// Optional watchdog on missing samples: define PART_PROFILE_TIMEOUT_EN.
module part_profile_capture
    import part_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int END_MARK = DEF_END_MARK,
    parameter int TOL      = DEF_TOL
`ifdef PART_PROFILE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 2**20
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              ccd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              overflow,
    output logic [ADDR_W-1:0] ref_len,
    output logic [ADDR_W-1:0] err_cnt,
    output logic [1:0]        state_o
);

    localparam logic [DATA_W-1:0] END_WORD = DATA_W'(END_MARK);
    localparam logic [ADDR_W-1:0] ADDR_OVF = {ADDR_W{1'b1}} - ADDR_W'(1);

    state_t            state, state_nxt;
    logic              mode_r;
    logic [ADDR_W-1:0] addr;
    logic              ovf_r;
    logic [ADDR_W-1:0] err_r;
    logic [ADDR_W-1:0] ref_r;
    logic [DATA_W-1:0] sample_r;
    logic              cmp_pend;
    logic              pass_r;
    logic              mismatch;
    logic              is_end;
    logic              take;
    logic              ovf_hit;
    logic              timeout_hit;
    logic              pass_now;

    profile_cmp #(.DATA_W(DATA_W), .TOL(TOL)) u_cmp (
        .sample   (sample_r),
        .ref_word (mem_rdata),
        .mismatch (mismatch)
    );

`ifdef PART_PROFILE_TIMEOUT_EN
    logic [31:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || in_valid || !(state == ST_SYNC || state == ST_ACQ))
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 32'd1;
    end

    assign timeout_hit = (state == ST_SYNC || state == ST_ACQ) && !in_valid &&
                         (idle_cnt == 32'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // A sample is taken when it is neither the line delimiter nor a blank (zero) reading.
    always_comb begin
        is_end  = in_valid && (in_data == END_WORD);
        take    = in_valid && !is_end && (in_data != '0) &&
                  (state == ST_SYNC || state == ST_ACQ);
        ovf_hit = take && (addr == ADDR_OVF);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start) state_nxt = ST_SYNC;
            ST_SYNC: begin
                if (ovf_hit || timeout_hit)  state_nxt = ST_FINISH;
                else if (in_valid && !is_end) state_nxt = ST_ACQ;
            end
            ST_ACQ:    if (is_end || ovf_hit || timeout_hit) state_nxt = ST_FINISH;
            ST_FINISH: state_nxt = ST_IDLE;
        endcase
    end

    // The last compare may still be in flight during FINISH, so fold it into the verdict.
    always_comb begin
        pass_now  = mode_r && !ovf_r && (addr == ref_r) && (err_r == '0) &&
                    !(cmp_pend && mismatch);
        busy      = (state != ST_IDLE);
        ccd_en    = (state == ST_SYNC) || (state == ST_ACQ);
        done      = (state == ST_FINISH);
        state_o   = state;
        mem_addr  = addr;
        mem_wren  = take && !mode_r;
        mem_wdata = mem_wren ? in_data : '0;
        pass      = (state == ST_FINISH) ? pass_now : pass_r;
        overflow  = ovf_r;
        ref_len   = ref_r;
        err_cnt   = err_r;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mode_r   <= 1'b0;
            addr     <= '0;
            ovf_r    <= 1'b0;
            err_r    <= '0;
            ref_r    <= '0;
            sample_r <= '0;
            cmp_pend <= 1'b0;
            pass_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cmp_pend <= take && mode_r;
            if (take) sample_r <= in_data;
            if (state == ST_IDLE && start) begin
                mode_r <= mode;
                addr   <= '0;
                ovf_r  <= 1'b0;
                err_r  <= '0;
                pass_r <= 1'b0;
            end else begin
                if (take) addr <= addr + ADDR_W'(1);
                if (ovf_hit || timeout_hit) ovf_r <= 1'b1;
                if (cmp_pend && mismatch && (err_r != {ADDR_W{1'b1}}))
                    err_r <= err_r + ADDR_W'(1);
                if (state == ST_FINISH) begin
                    pass_r <= pass_now;
                    if (!mode_r && !ovf_r) ref_r <= addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_part_profile_capture.sv
// Randomized bench for part_profile_capture with a list-based reference model of scan lines.
module tb_part_profile_capture;

  localparam int DW   = 12;
  localparam int AW   = 10;
  localparam int AW2  = 3;
  localparam int ENDM = 882;
  localparam int TOLV = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic          rst_n, start, start2, mode, in_valid, ram_clr;
  logic [DW-1:0] in_data;

  logic          ccd_en1, wren1, busy1, done1, pass1, ovf1;
  logic [AW-1:0] addr1, ref1, err1;
  logic [DW-1:0] wdata1, rdata1;
  logic [1:0]    state1;

  logic           ccd_en2, wren2, busy2, done2, pass2, ovf2;
  logic [AW2-1:0] addr2, ref2, err2;
  logic [DW-1:0]  wdata2, rdata2;
  logic [1:0]     state2;

  part_profile_capture #(
    .TOL(TOLV)
`ifdef PART_PROFILE_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .in_valid(in_valid),
    .in_data(in_data), .ccd_en(ccd_en1), .mem_addr(addr1), .mem_wdata(wdata1),
    .mem_wren(wren1), .mem_rdata(rdata1), .busy(busy1), .done(done1), .pass(pass1),
    .overflow(ovf1), .ref_len(ref1), .err_cnt(err1), .state_o(state1)
  );

  part_profile_capture #(.ADDR_W(AW2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode), .in_valid(in_valid),
    .in_data(in_data), .ccd_en(ccd_en2), .mem_addr(addr2), .mem_wdata(wdata2),
    .mem_wren(wren2), .mem_rdata(rdata2), .busy(busy2), .done(done2), .pass(pass2),
    .overflow(ovf2), .ref_len(ref2), .err_cnt(err2), .state_o(state2)
  );

  // Profile memories (environment, one-cycle read latency)
  logic [DW-1:0] ram1 [2**AW];
  logic [DW-1:0] ram2 [2**AW2];

  always @(posedge clk) begin
    if (ram_clr) for (int i = 0; i < 2**AW; i++) ram1[i] <= '0;
    else if (wren1) ram1[addr1] <= wdata1;
    rdata1 <= ram1[addr1];
  end

  always @(posedge clk) begin
    if (ram_clr) for (int i = 0; i < 2**AW2; i++) ram2[i] <= '0;
    else if (wren2) ram2[addr2] <= wdata2;
    rdata2 <= ram2[addr2];
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  int  smp[$];
  int  prof[$];
  int  base[$];
  int  mm1 [2**AW];
  int  mm2 [2**AW2];
  int  mref1 = 0;
  int  mref2 = 0;
  logic [31:0] exp_q[$];
  bit  exp_ovf, exp_pass;
  bit  sel;

  // Profile = non-zero samples from the first non-delimiter up to the next delimiter,
  // cut short once depth-1 samples have been taken.
  task automatic build_profile(input int depth, output bit ovf);
    bit acq, fin;
    prof.delete();
    ovf = 0; acq = 0; fin = 0;
    foreach (smp[i]) begin
      if (ovf || fin) continue;
      if (!acq) begin
        if (smp[i] == ENDM) continue;
        acq = 1;
      end else if (smp[i] == ENDM) begin
        fin = 1;
        continue;
      end
      if (smp[i] == 0) continue;
      prof.push_back(smp[i]);
      if (prof.size() == depth - 1) ovf = 1;
    end
  endtask

  // Selected DUT outputs
  logic        o_busy, o_done, o_pass, o_ovf, o_wren;
  logic [31:0] o_err, o_ref, o_waddr, o_wdata;
  assign o_busy  = sel ? busy2 : busy1;
  assign o_done  = sel ? done2 : done1;
  assign o_pass  = sel ? pass2 : pass1;
  assign o_ovf   = sel ? ovf2  : ovf1;
  assign o_wren  = sel ? wren2 : wren1;
  assign o_err   = sel ? 32'(err2)  : 32'(err1);
  assign o_ref   = sel ? 32'(ref2)  : 32'(ref1);
  assign o_waddr = sel ? 32'(addr2) : 32'(addr1);
  assign o_wdata = sel ? 32'(wdata2) : 32'(wdata1);

  // Scoreboard monitor: memory writes and done pulses
  int   done_cnt = 0;
  logic prev_done = 1'b0;
  logic [31:0] w;

  always @(negedge clk) begin
    if (o_wren === 1'b1) begin
      check("wr_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("wr_word", (o_waddr << 16) | o_wdata, w);
      end
    end
    if (o_done === 1'b1) begin
      done_cnt++;
      check("done_width", 32'(prev_done), 0);
      check("done_ovf", 32'(o_ovf), 32'(exp_ovf));
      check("done_pass", 32'(o_pass), 32'(exp_pass));
    end
    prev_done = o_done;
  end

  // ---------------- driver ----------------
  task automatic run_op(input bit s, input bit md, input bit poke);
    int depth, nerr, mr, d0, cyc, v;
    bit ovf;
    sel   = s;
    depth = s ? 2**AW2 : 2**AW;
    mr    = s ? mref2 : mref1;
    build_profile(depth, ovf);
    nerr = 0;
    foreach (prof[k]) begin
      if (!md) exp_q.push_back(32'((k << 16) | prof[k]));
      else begin
        v = prof[k] - (s ? mm2[k] : mm1[k]);
        if (v < 0) v = -v;
        if (v > TOLV) nerr++;
      end
    end
    if (nerr > depth - 1) nerr = depth - 1;
    exp_ovf  = ovf;
    exp_pass = md && (nerr == 0) && (prof.size() == mr) && !ovf;
    d0 = done_cnt;

    @(posedge clk); #1;
    if (s) start2 = 1'b1; else start = 1'b1;
    mode = md;
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
    foreach (smp[i]) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = DW'(smp[i]);
      if (poke && i == 1) begin start = 1'b1; mode = ~md; end
      @(posedge clk); #1;
      in_valid = 1'b0; start = 1'b0; mode = md;
    end
    cyc = 0;
    while (o_busy !== 1'b0 && cyc < 100) begin @(negedge clk); cyc++; end
    check("op_end", 32'(o_busy), 0);
    repeat (2) @(negedge clk);
    check("done_count", 32'(done_cnt - d0), 1);
    check("err_cnt", o_err, 32'(nerr));
    check("pass_hold", 32'(o_pass), 32'(exp_pass));
    check("overflow", 32'(o_ovf), 32'(ovf));
    check("wr_left", 32'(exp_q.size()), 0);
    if (!md) begin
      foreach (prof[k]) if (s) mm2[k] = prof[k]; else mm1[k] = prof[k];
      if (!ovf) begin if (s) mref2 = prof.size(); else mref1 = prof.size(); end
    end
    check("ref_len", o_ref, 32'(s ? mref2 : mref1));
  endtask

  function automatic int rnd_word();
    int v;
    v = int'($urandom_range(1, 4095));
    while (v == ENDM) v = int'($urandom_range(1, 4095));
    return v;
  endfunction

  // ---------------- main sequence ----------------
  int n, len, v, cyc, d0;

  initial begin
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; mode = 1'b0;
    in_valid = 1'b0; in_data = '0; ram_clr = 1'b1; sel = 1'b0;
    exp_ovf = 1'b0; exp_pass = 1'b0;
    foreach (mm1[i]) mm1[i] = 0;
    foreach (mm2[i]) mm2[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state1), 0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_ccd_en", 32'(ccd_en1), 0);
    check("rst_wren", 32'(wren1), 0);
    check("rst_done", 32'(done1), 0);
    check("rst_pass", 32'(pass1), 0);
    check("rst_ovf", 32'(ovf1), 0);
    check("rst_addr", 32'(addr1), 0);
    check("rst_wdata", 32'(wdata1), 0);
    check("rst_err", 32'(err1), 0);
    check("rst_ref", 32'(ref1), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; ram_clr = 1'b0;

    // Directed learn / inspect lines
    smp = '{882, 882, 100, 0, 120, 130, 882};
    run_op(0, 0, 0);
    check("learn_ref_len3", 32'(ref1), 3);
    smp = '{882, 102, 0, 118, 133, 882};
    run_op(0, 1, 0);
    check("inspect_match_pass", 32'(pass1), 1);
    smp = '{882, 100, 140, 130, 882};
    run_op(0, 1, 0);
    check("inspect_mis_err", 32'(err1), 1);
    smp = '{882, 100, 120, 882};
    run_op(0, 1, 0);
    check("inspect_short_pass", 32'(pass1), 0);

    // Learn with a stray start (and opposite mode) while busy
    smp = '{882, 100, 120, 130, 882};
    run_op(0, 0, 1);

    // Random learn / inspect pairs
    for (int r = 0; r < 10; r++) begin
      n = int'($urandom_range(1, 20));
      base.delete(); smp.delete();
      repeat ($urandom_range(0, 3)) smp.push_back(ENDM);
      for (int k = 0; k < n; k++) begin
        base.push_back(rnd_word());
        smp.push_back(base[k]);
        if ($urandom_range(0, 3) == 0) smp.push_back(0);
      end
      smp.push_back(ENDM);
      run_op(0, 0, 0);
      smp.delete();
      smp.push_back(ENDM);
      len = n;
      if ($urandom_range(0, 3) == 0) len = int'($urandom_range(1, n + 2));
      for (int k = 0; k < len; k++) begin
        if (k < n) v = base[k] + int'($urandom_range(0, 12)) - 6;
        else       v = rnd_word();
        if (v < 1) v = 1;
        if (v > 4095) v = 4095;
        if (v == ENDM) v = ENDM + 1;
        smp.push_back(v);
        if ($urandom_range(0, 4) == 0) smp.push_back(0);
      end
      smp.push_back(ENDM);
      run_op(0, 1, 0);
    end

    // Overflow on the 8-deep instance
    smp = '{201, 202, 203, 204, 205, 206, 207, 208};
    run_op(1, 0, 0);
    check("ovf_ref_unchanged", 32'(ref2), 0);
    check("ovf_flag", 32'(ovf2), 1);

    // Reset in the middle of acquisition
    sel = 1'b0;
    exp_q.push_back(32'(300));
    @(posedge clk); #1; start = 1'b1; mode = 1'b0;
    @(posedge clk); #1; start = 1'b0; in_valid = 1'b1; in_data = DW'(882);
    @(posedge clk); #1; in_data = DW'(300);
    @(posedge clk); #1; in_valid = 1'b0;
    mm1[0] = 300;
    @(negedge clk);
    check("mid_state_acq", 32'(state1), 2);
    check("mid_ccd_en", 32'(ccd_en1), 1);
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    mref1 = 0;
    check("mid_rst_state", 32'(state1), 0);
    check("mid_rst_ccd_en", 32'(ccd_en1), 0);
    check("mid_rst_wren", 32'(wren1), 0);
    check("mid_rst_busy", 32'(busy1), 0);
    check("mid_rst_ref", 32'(ref1), 0);
    check("mid_wr_left", 32'(exp_q.size()), 0);

    // Recovery after reset
    smp = '{882, 500, 600, 882};
    run_op(0, 0, 0);
    smp = '{882, 503, 596, 882};
    run_op(0, 1, 0);

`ifdef PART_PROFILE_TIMEOUT_EN
    // Watchdog: no samples at all after start
    sel = 1'b0; exp_ovf = 1'b1; exp_pass = 1'b0; d0 = done_cnt;
    @(posedge clk); #1; start = 1'b1; mode = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (busy1 !== 1'b0 && cyc < 60) begin @(negedge clk); cyc++; end
    check("to_end", 32'(busy1), 0);
    check("to_done", 32'(done_cnt - d0), 1);
    check("to_ovf", 32'(ovf1), 1);
    check("to_pass", 32'(pass1), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
